// File: rtl/ise_pkg.sv
// Shared constants and types for the image statistics block.
// Contents:
//   IMAGE_SIZE / PIX_PER_IMG / PIX_W : image geometry (128x128 pixels)
//   IMAGE_NUM                        : number of records that completes a batch
//   COLOR_R/G/B                      : dominant colour encoding on rec_color
//   rec_t                            : per-image record {index, color, avg}
//   state_t                          : accumulate / emit FSM states
package ise_pkg;
    localparam int IMAGE_SIZE  = 128;
    localparam int PIX_PER_IMG = IMAGE_SIZE * IMAGE_SIZE;
    localparam int PIX_W       = $clog2(PIX_PER_IMG);
    localparam int IMAGE_NUM   = 32;

    localparam logic [1:0] COLOR_R = 2'd0;
    localparam logic [1:0] COLOR_G = 2'd1;
    localparam logic [1:0] COLOR_B = 2'd2;

    typedef struct packed {
        logic [4:0] index;
        logic [1:0] color;
        logic [7:0] avg;
    } rec_t;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/ise_img_stat_if.sv
// Bundle of the pixel stream and record handshake signals of ise_img_stat.
// master : pixel source / record sink (drives pixels and rec_ready)
// slave  : the statistics block (drives busy, record and status flags)
interface ise_img_stat_if;
    logic        pix_valid;
    logic [4:0]  image_in_index;
    logic [23:0] pixel_in;
    logic        busy;
    logic        rec_valid;
    logic        rec_ready;
    logic [4:0]  rec_index;
    logic [1:0]  rec_color;
    logic [7:0]  rec_avg;
    logic        index_err;
    logic        all_done;

    modport master (
        output pix_valid, image_in_index, pixel_in, rec_ready,
        input  busy, rec_valid, rec_index, rec_color, rec_avg, index_err, all_done
    );
    modport slave (
        input  pix_valid, image_in_index, pixel_in, rec_ready,
        output busy, rec_valid, rec_index, rec_color, rec_avg, index_err, all_done
    );
endinterface

// File: rtl/ise_pix_class.sv
// Combinational three-way classifier: picks the largest of three unsigned
// W-bit fields packed {R, G, B}, ties resolved R > G > B.
// W=8 classifies a 24-bit pixel; a wider W classifies the per-class counts.
// Ports:
//   i_pix   : {R, G, B}, each W bits
//   o_class : COLOR_R / COLOR_G / COLOR_B
module ise_pix_class
    import ise_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3*W-1:0] i_pix,
    output logic [1:0]     o_class
);
    logic [W-1:0] w_r, w_g, w_b;

    assign w_r = i_pix[3*W-1:2*W];
    assign w_g = i_pix[2*W-1:W];
    assign w_b = i_pix[W-1:0];

    always_comb begin
        o_class = COLOR_B;
        if (w_r >= w_g && w_r >= w_b)
            o_class = COLOR_R;
        else if (w_g >= w_b)
            o_class = COLOR_G;
    end
endmodule

// File: rtl/ise_img_stat.sv
// Per-image colour statistics. Pixels stream in one per cycle; each is
// classified by its dominant channel, counted, and its channels summed.
// After 2**PIX_W_P pixels the block stalls the stream (busy) and offers one
// record {index, dominant colour, mean of that channel} until accepted.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   pix_valid         : pixel_in / image_in_index valid
//   image_in_index    : image number of the current pixel
//   pixel_in          : {R, G, B} 8 bits each
//   busy              : pixel not accepted this cycle
//   rec_valid/ready   : record handshake
//   rec_index/color/avg : record fields
//   index_err         : sticky, image index changed inside an image
//   all_done          : IMAGE_NUM records handed off (sticky)
// PIX_W_P shrinks the image length for fast simulation; keep the default.
module ise_img_stat
    import ise_pkg::*;
#(
    parameter int PIX_W_P = PIX_W
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [4:0]  image_in_index,
    input  logic [23:0] pixel_in,
    output logic        busy,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [4:0]  rec_index,
    output logic [1:0]  rec_color,
    output logic [7:0]  rec_avg,
    output logic        index_err,
    output logic        all_done
);
    localparam int CNT_W = PIX_W_P + 1;  // holds a full image of one class
    localparam int SUM_W = PIX_W_P + 8;

    state_t                      r_state, w_state_nxt;
    logic [PIX_W_P-1:0]          r_pix_cnt;
    logic [2:0][CNT_W-1:0]       r_cnt;
    logic [2:0][SUM_W-1:0]       r_sum;
    logic [4:0]                  r_idx;
    logic                        r_index_err;
    logic [5:0]                  r_done_cnt;

    logic                        w_accept, w_last, w_hs;
    logic [1:0]                  w_pix_class, w_img_class;
    logic [2:0][7:0]             w_chan;
    rec_t                        w_rec;

    // channel order matches the colour encoding: [0]=R, [1]=G, [2]=B
    assign w_chan[COLOR_R] = pixel_in[23:16];
    assign w_chan[COLOR_G] = pixel_in[15:8];
    assign w_chan[COLOR_B] = pixel_in[7:0];

    assign w_accept = pix_valid && (r_state == ST_ACC);
    assign w_last   = w_accept && (r_pix_cnt == {PIX_W_P{1'b1}});
    assign w_hs     = (r_state == ST_EMIT) && rec_ready;

    ise_pix_class #(.W(8)) u_pix_class (
        .i_pix   (pixel_in),
        .o_class (w_pix_class)
    );

    // Same tie rules decide the image: largest class count wins.
    ise_pix_class #(.W(CNT_W)) u_img_class (
        .i_pix   ({r_cnt[COLOR_R], r_cnt[COLOR_G], r_cnt[COLOR_B]}),
        .o_class (w_img_class)
    );

    // Accumulators are frozen outside ACC, so the record derived from them
    // stays stable for the whole EMIT wait.
    always_comb begin
        w_rec       = '0;
        w_rec.index = r_idx;
        w_rec.color = w_img_class;
        case (w_img_class)
            COLOR_G: w_rec.avg = r_sum[COLOR_G][SUM_W-1 -: 8];
            COLOR_B: w_rec.avg = r_sum[COLOR_B][SUM_W-1 -: 8];
            default: w_rec.avg = r_sum[COLOR_R][SUM_W-1 -: 8];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= ST_ACC;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACC:  if (w_last) w_state_nxt = ST_EMIT;
            ST_EMIT: if (w_hs)   w_state_nxt = ST_ACC;
            default: w_state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_cnt   <= '0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_idx       <= '0;
            r_index_err <= 1'b0;
            r_done_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;  // wraps to 0 on the last pixel
                for (int c = 0; c < 3; c++) begin
                    if (w_pix_class == 2'(c))
                        r_cnt[c] <= r_cnt[c] + 1'b1;
                    r_sum[c] <= r_sum[c] + SUM_W'(w_chan[c]);
                end
                if (r_pix_cnt == '0)
                    r_idx <= image_in_index;
                else if (image_in_index != r_idx)
                    r_index_err <= 1'b1;
            end
            if (w_hs) begin
                r_cnt <= '0;
                r_sum <= '0;
                if (r_done_cnt != 6'(IMAGE_NUM))
                    r_done_cnt <= r_done_cnt + 1'b1;
            end
        end
    end

    assign busy      = (r_state == ST_EMIT);
    assign rec_valid = (r_state == ST_EMIT);
    assign rec_index = w_rec.index;
    assign rec_color = w_rec.color;
    assign rec_avg   = w_rec.avg;
    assign index_err = r_index_err;
    assign all_done  = (r_done_cnt == 6'(IMAGE_NUM));
endmodule

// File: tb/tb_ise_img_stat.sv
// Directed bench for ise_img_stat. Instance A runs full 16384-pixel images;
// instance B uses 16-pixel images for the stall, batch-count and reset cases.
module tb_ise_img_stat;
    import ise_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int   n_cmp, n_bad;

    ise_img_stat_if ia ();
    ise_img_stat_if ib ();

    ise_img_stat u_dut_a (
        .clk(clk), .reset(rst_a),
        .pix_valid(ia.pix_valid), .image_in_index(ia.image_in_index), .pixel_in(ia.pixel_in),
        .busy(ia.busy), .rec_valid(ia.rec_valid), .rec_ready(ia.rec_ready),
        .rec_index(ia.rec_index), .rec_color(ia.rec_color), .rec_avg(ia.rec_avg),
        .index_err(ia.index_err), .all_done(ia.all_done)
    );

    ise_img_stat #(.PIX_W_P(4)) u_dut_b (
        .clk(clk), .reset(rst_b),
        .pix_valid(ib.pix_valid), .image_in_index(ib.image_in_index), .pixel_in(ib.pixel_in),
        .busy(ib.busy), .rec_valid(ib.rec_valid), .rec_ready(ib.rec_ready),
        .rec_index(ib.rec_index), .rec_color(ib.rec_color), .rec_avg(ib.rec_avg),
        .index_err(ib.index_err), .all_done(ib.all_done)
    );

    // Offer n identical pixels, one per cycle, starting at posedge+1.
    task automatic stream(input bit sel, input int n, input logic [23:0] px, input logic [4:0] idx);
        for (int i = 0; i < n; i++) begin
            if (sel) begin
                ib.pix_valid = 1'b1; ib.pixel_in = px; ib.image_in_index = idx;
            end else begin
                ia.pix_valid = 1'b1; ia.pixel_in = px; ia.image_in_index = idx;
            end
            @(posedge clk); #1;
        end
        if (sel) ib.pix_valid = 1'b0; else ia.pix_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [18:0] got;
        #2; rst_a = 1'b1; rst_b = 1'b1;
        #2;
        got = {ia.busy, ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg, ia.index_err, ia.all_done};
        n_cmp++;
        if (got !== 19'd0) begin n_bad++; $display("FAIL reset_a: got %h want 0", got); end
        got = {ib.busy, ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg, ib.index_err, ib.all_done};
        n_cmp++;
        if (got !== 19'd0) begin n_bad++; $display("FAIL reset_b: got %h want 0", got); end
        @(negedge clk); rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single_colour();
        ia.rec_ready = 1'b1;
        stream(0, 16383, 24'hFF0000, 5'd3);
        n_cmp++;
        if ({ia.busy, ia.rec_valid} !== 2'b00) begin
            n_bad++; $display("FAIL red_early: busy/valid %b want 00", {ia.busy, ia.rec_valid});
        end
        stream(0, 1, 24'hFF0000, 5'd3);
        n_cmp++;
        if ({ia.busy, ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg} !== {2'b11, 5'd3, 2'd0, 8'd255}) begin
            n_bad++; $display("FAIL red_rec: b%b v%b idx %0d col %0d avg %0d want 1 1 3 0 255",
                              ia.busy, ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg);
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({ia.busy, ia.rec_valid} !== 2'b00) begin
            n_bad++; $display("FAIL red_busy_len: busy/valid %b want 00", {ia.busy, ia.rec_valid});
        end
    endtask

    task automatic test_tie();
        stream(0, 8192, 24'h00FF00, 5'd4);
        stream(0, 8192, 24'h0000FF, 5'd4);
        n_cmp++;
        if ({ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg, ia.index_err} !== {1'b1, 5'd4, 2'd1, 8'd127, 1'b0}) begin
            n_bad++; $display("FAIL gb_tie: v%b idx %0d col %0d avg %0d err %b want 1 4 1 127 0",
                              ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg, ia.index_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_index_err();
        stream(0, 100, 24'h102030, 5'd5);
        n_cmp++;
        if (ia.index_err !== 1'b0) begin n_bad++; $display("FAIL idx_err_early: got %b want 0", ia.index_err); end
        stream(0, 1, 24'h102030, 5'd6);
        n_cmp++;
        if (ia.index_err !== 1'b1) begin n_bad++; $display("FAIL idx_err_set: got %b want 1", ia.index_err); end
        stream(0, 16283, 24'h102030, 5'd6);
        n_cmp++;
        if ({ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg, ia.index_err} !== {1'b1, 5'd5, 2'd2, 8'h30, 1'b1}) begin
            n_bad++; $display("FAIL idx_err_rec: v%b idx %0d col %0d avg %h err %b want 1 5 2 30 1",
                              ia.rec_valid, ia.rec_index, ia.rec_color, ia.rec_avg, ia.index_err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (ia.index_err !== 1'b1) begin n_bad++; $display("FAIL idx_err_sticky: got %b want 1", ia.index_err); end
        rst_a = 1'b1; #1;
        n_cmp++;
        if ({ia.index_err, ia.rec_index} !== 6'd0) begin
            n_bad++; $display("FAIL idx_err_reset: err %b idx %0d want 0 0", ia.index_err, ia.rec_index);
        end
        @(negedge clk); rst_a = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_and_grey();
        ib.rec_ready = 1'b1;
        stream(1, 16, 24'h000000, 5'd1);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg} !== {1'b1, 5'd1, 2'd0, 8'd0}) begin
            n_bad++; $display("FAIL zero_img: v%b idx %0d col %0d avg %0d want 1 1 0 0",
                              ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg);
        end
        @(posedge clk); #1;
        stream(1, 16, 24'h808080, 5'd2);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg} !== {1'b1, 5'd2, 2'd0, 8'h80}) begin
            n_bad++; $display("FAIL grey_img: v%b idx %0d col %0d avg %h want 1 2 0 80",
                              ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        ib.rec_ready = 1'b0;
        stream(1, 10, 24'h00FF00, 5'd9);
        stream(1, 6, 24'h0000FF, 5'd9);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg} !== {1'b1, 5'd9, 2'd1, 8'd159}) begin
            n_bad++; $display("FAIL stall_rec: v%b idx %0d col %0d avg %0d want 1 9 1 159",
                              ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg);
        end
        ib.pix_valid = 1'b1; ib.pixel_in = 24'h0000FF; ib.image_in_index = 5'd12;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({ib.busy, ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg} !== {2'b11, 5'd9, 2'd1, 8'd159}) begin
                n_bad++; $display("FAIL stall_hold[%0d]: b%b v%b idx %0d col %0d avg %0d want 1 1 9 1 159", c,
                                  ib.busy, ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg);
            end
        end
        ib.rec_ready = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ib.busy !== 1'b0) begin n_bad++; $display("FAIL stall_release: busy %b want 0", ib.busy); end
        stream(1, 15, 24'h0000FF, 5'd12);
        n_cmp++;
        if (ib.rec_valid !== 1'b0) begin n_bad++; $display("FAIL stall_position: rec_valid %b want 0", ib.rec_valid); end
        stream(1, 1, 24'h0000FF, 5'd12);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg, ib.index_err} !== {1'b1, 5'd12, 2'd2, 8'd255, 1'b0}) begin
            n_bad++; $display("FAIL stall_next: v%b idx %0d col %0d avg %0d err %b want 1 12 2 255 0",
                              ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg, ib.index_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [23:0] px;
        logic [1:0]  col;
        rst_b = 1'b1; #1;
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            px  = i[0] ? 24'h0000FF : 24'hFF0000;
            col = i[0] ? 2'd2 : 2'd0;
            stream(1, 16, px, 5'(i));
            n_cmp++;
            if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.all_done} !== {1'b1, 5'(i), col, 1'b0}) begin
                n_bad++; $display("FAIL b2b_rec[%0d]: v%b idx %0d col %0d done %b want 1 %0d %0d 0", i,
                                  ib.rec_valid, ib.rec_index, ib.rec_color, ib.all_done, i, col);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (ib.all_done !== (i == 31)) begin
                n_bad++; $display("FAIL b2b_done[%0d]: got %b want %b", i, ib.all_done, (i == 31));
            end
        end
        stream(1, 16, 24'h00FF00, 5'd31);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_color, ib.all_done} !== {1'b1, 2'd1, 1'b1}) begin
            n_bad++; $display("FAIL after_done: v%b col %0d done %b want 1 1 1",
                              ib.rec_valid, ib.rec_color, ib.all_done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_image();
        logic [18:0] got;
        rst_b = 1'b1; #1;
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            stream(1, 16, 24'hFF0000, 5'(i));
            @(posedge clk); #1;
        end
        stream(1, 7, 24'h00FF00, 5'd10);
        n_cmp++;
        if (ib.rec_index !== 5'd10) begin n_bad++; $display("FAIL mid_latch: idx %0d want 10", ib.rec_index); end
        rst_b = 1'b1; #1;
        got = {ib.busy, ib.rec_valid, ib.rec_index, ib.rec_color, ib.rec_avg, ib.index_err, ib.all_done};
        n_cmp++;
        if (got !== 19'd0) begin n_bad++; $display("FAIL mid_reset: got %h want 0", got); end
        @(negedge clk); rst_b = 1'b0;
        @(posedge clk); #1;
        stream(1, 15, 24'h0000FF, 5'd20);
        n_cmp++;
        if (ib.rec_valid !== 1'b0) begin n_bad++; $display("FAIL mid_discard: rec_valid %b want 0", ib.rec_valid); end
        stream(1, 1, 24'h0000FF, 5'd20);
        n_cmp++;
        if ({ib.rec_valid, ib.rec_index, ib.rec_color, ib.all_done} !== {1'b1, 5'd20, 2'd2, 1'b0}) begin
            n_bad++; $display("FAIL mid_new_img: v%b idx %0d col %0d done %b want 1 20 2 0",
                              ib.rec_valid, ib.rec_index, ib.rec_color, ib.all_done);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_a = 1'b0; rst_b = 1'b0;
        ia.pix_valid = 1'b0; ia.pixel_in = '0; ia.image_in_index = '0; ia.rec_ready = 1'b0;
        ib.pix_valid = 1'b0; ib.pixel_in = '0; ib.image_in_index = '0; ib.rec_ready = 1'b0;
        test_reset();
        test_single_colour();
        test_tie();
        test_index_err();
        test_zero_and_grey();
        test_stall();
        test_back_to_back();
        test_reset_mid_image();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end
endmodule
